multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Issue/handshake stage directly upstream of the Booth multiplier and the companion divider. It accepts a one-cycle mult/div request from the execute stage and latches the operands. It launches the selected unit, stalls the pipeline while the unit iterates, then consumes product/resultRDY/overflow and presents a single-cycle registered result with exception and destination tag to writeback.

Parameters:
MAX_CYCLES, 40, watchdog limit in WAIT cycles before a forced exception
TAG_W, 5, width of the destination-register tag carried with the op

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; clears all state and outputs
ctrl_MULT  in  1  one-cycle multiply request
ctrl_DIV  in  1  one-cycle divide request
data_operandA  in  32  multiplicand / dividend
data_operandB  in  32  multiplier / divisor
dest_tag  in  TAG_W  destination register of the op
mult_start  out  1  one-cycle pulse wired to the multiplier's reset (load) input
mult_multiplicand  out  32  latched operand A to the multiplier
mult_multiplier  out  32  latched operand B to the multiplier
mult_product  in  32  multiplier product
mult_resultRDY  in  1  multiplier done
mult_overflow  in  1  multiplier overflow
div_start  out  1  one-cycle load pulse to the divider
div_dividend  out  32  latched operand A
div_divisor  out  32  latched operand B
div_quotient  in  32  divider result
div_resultRDY  in  1  divider done
div_exception  in  1  divider exception
stall  out  1  high while an op is in flight
data_result  out  32  registered result
data_exception  out  1  overflow / div-by-zero / timeout
data_resultRDY  out  1  one-cycle result-valid strobe
result_tag  out  TAG_W  dest_tag of the completed op

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0, including operand registers, result, tag and watchdog counter. A reset mid-operation abandons the op with no resultRDY strobe.
- States: IDLE, LAUNCH, WAIT, DONE. The encoding is 2-bit; IDLE=0.
- IDLE: on ctrl_MULT or ctrl_DIV, latch A, B, dest_tag and op type (op=MULT if ctrl_MULT is high, so MULT wins when both are high), then go to LAUNCH. Exception: DIV with B==0 goes straight to DONE with result 0 and exception 1, and no unit is launched.
- LAUNCH (one cycle): assert mult_start or div_start for exactly this cycle. stall=1. Clear the watchdog and go to WAIT.
- WAIT: stall=1; watchdog increments each cycle.
  - The selected unit's resultRDY is sampled only here. A stale resultRDY from the previous op is masked because it is never sampled in LAUNCH.
  - On resultRDY: capture product/quotient into data_result, capture overflow/exception into data_exception, go to DONE.
  - If the watchdog reaches MAX_CYCLES without resultRDY: result 0, exception 1, go to DONE.
- DONE (one cycle): data_resultRDY=1 and result_tag valid; stall=0; return to IDLE.
  - data_result, data_exception and result_tag hold until the next DONE.
  - data_resultRDY is 0 in every state except DONE.
- Requests arriving in LAUNCH, WAIT or DONE are ignored. The pipeline must not issue while stall=1, and no queueing is done.
- Operand outputs to both units remain stable from LAUNCH through DONE.
- Latency: request at cycle 0 → mult_start at cycle 1 → DONE one cycle after resultRDY is seen. For the 32-bit radix-4 Booth multiplier (16 iterations), data_resultRDY arrives about 19 cycles after the request.

Decomposition:
- A shared package multdiv_pkg holds:
  - the state enum (IDLE/LAUNCH/WAIT/DONE)
  - the op-type constant (OP_MULT=0, OP_DIV=1)
  - the MAX_CYCLES default and TAG_W default
- One natural sub-module is multdiv_watchdog: a counter with clear/enable and a terminal-count flag. Everything else stays flat.

Test Plan:
- A=2, B=7, ctrl_MULT pulse, real multiplier attached → mult_start high exactly 1 cycle; stall high until DONE; data_result=14, exception=0, resultRDY single-cycle, result_tag echoes dest_tag=5'd3.
- A=-5, B=3 MULT → data_result=32'hFFFFFFF1, exception 0. Then A=32'h7FFFFFFF, B=2 → mult_overflow propagates as data_exception=1.
- ctrl_DIV with A=100, B=0 → no div_start; DONE one cycle after the request; result 0, exception 1, stall never high.
- Stub unit that never raises resultRDY → data_resultRDY with exception=1 and result 0 exactly MAX_CYCLES cycles into WAIT (request + 42 cycles at default).
- Second ctrl_MULT (A=3, B=3) issued during WAIT of a 2*7 op → ignored; only one strobe with 14. Stub holding resultRDY high from the prior op → not sampled in LAUNCH.
- reset asserted mid-WAIT → next edge all outputs 0, state IDLE, no strobe. A fresh ctrl_MULT afterwards completes normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the mult/div issue stage.
// Imported by the controller and its watchdog.
package multdiv_pkg;

  localparam int MAX_CYCLES_DEF = 40;
  localparam int TAG_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/multdiv_watchdog.sv
// Cycle counter bounding how long the stage waits on a unit.
// tc fires on the LIMIT-th enabled cycle after a clear.
module multdiv_watchdog
  import multdiv_pkg::*;
#(
  parameter int LIMIT = MAX_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign tc = en && (count == CW'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue stage for the Booth multiplier and divider: latches
// operands, launches one unit, stalls, then strobes the result.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [31:0]      data_operandA,
  input  logic [31:0]      data_operandB,
  input  logic [TAG_W-1:0] dest_tag,
  output logic             mult_start,
  output logic [31:0]      mult_multiplicand,
  output logic [31:0]      mult_multiplier,
  input  logic [31:0]      mult_product,
  input  logic             mult_resultRDY,
  input  logic             mult_overflow,
  output logic             div_start,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic             div_resultRDY,
  input  logic             div_exception,
  output logic             stall,
  output logic [31:0]      data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAG_W-1:0] result_tag
);

  state_t state, state_n;
  op_t op_q;
  logic [31:0] opa_q, opb_q;
  logic [TAG_W-1:0] tag_q;

  logic ld, fin, exc_n, wd_tc;
  logic [31:0] res_n;
  logic unit_rdy, unit_exc;
  logic [31:0] unit_res;

  assign unit_rdy = (op_q == OP_MULT) ? mult_resultRDY : div_resultRDY;
  assign unit_res = (op_q == OP_MULT) ? mult_product : div_quotient;
  assign unit_exc = (op_q == OP_MULT) ? mult_overflow : div_exception;

  assign mult_start = (state == LAUNCH) && (op_q == OP_MULT);
  assign div_start = (state == LAUNCH) && (op_q == OP_DIV);
  assign stall = (state == LAUNCH) || (state == WAIT);
  assign data_resultRDY = (state == DONE);

  assign mult_multiplicand = opa_q;
  assign mult_multiplier = opb_q;
  assign div_dividend = opa_q;
  assign div_divisor = opb_q;

  multdiv_watchdog #(
    .LIMIT(MAX_CYCLES)
  ) u_wd (
    .clock(clock),
    .reset(reset),
    .clr  (state == LAUNCH),
    .en   (state == WAIT),
    .tc   (wd_tc)
  );

  always_comb begin
    state_n = state;
    ld = 1'b0;
    fin = 1'b0;
    res_n = '0;
    exc_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_MULT || ctrl_DIV) begin
          ld = 1'b1;
          // Divide by zero never reaches the divider.
          if (!ctrl_MULT && data_operandB == '0) begin
            fin = 1'b1;
            exc_n = 1'b1;
            state_n = DONE;
          end else begin
            state_n = LAUNCH;
          end
        end
      end
      LAUNCH: state_n = WAIT;
      WAIT: begin
        if (unit_rdy) begin
          fin = 1'b1;
          res_n = unit_res;
          exc_n = unit_exc;
          state_n = DONE;
        end else if (wd_tc) begin
          fin = 1'b1;
          exc_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op_q <= OP_MULT;
      opa_q <= '0;
      opb_q <= '0;
      tag_q <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      result_tag <= '0;
    end else begin
      state <= state_n;
      if (ld) begin
        op_q <= ctrl_MULT ? OP_MULT : OP_DIV;
        opa_q <= data_operandA;
        opb_q <= data_operandB;
        tag_q <= dest_tag;
      end
      if (fin) begin
        data_result <= res_n;
        data_exception <= exc_n;
        result_tag <= (state == IDLE) ? dest_tag : tag_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with behavioural unit stubs
// and a transaction-level expectation queue.
module tb_multdiv_ctrl;

  localparam int TW = 5;
  localparam int MAXC = 40;
  localparam int MLAT = 16;
  localparam int DLAT = 32;
  localparam longint PMAX = 64'sh7FFFFFFF;
  localparam longint PMIN = -PMAX - 1;

  logic clock = 0;
  logic reset = 1;
  logic ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] data_operandA = 0, data_operandB = 0;
  logic [TW-1:0] dest_tag = 0;
  logic mult_start, div_start, stall;
  logic [31:0] mult_multiplicand, mult_multiplier;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] mult_product = 0, div_quotient = 0;
  logic mult_resultRDY = 0, mult_overflow = 0;
  logic div_resultRDY = 0, div_exception = 0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY;
  logic [TW-1:0] result_tag;

  int nvec = 0;
  int nerr = 0;
  bit mhang = 0;
  int mcnt = 0;
  int dcnt = 0;

  typedef struct {
    logic [31:0] r;
    logic x;
    logic [TW-1:0] t;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  multdiv_ctrl #(.MAX_CYCLES(MAXC), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .dest_tag(dest_tag),
    .mult_start(mult_start),
    .mult_multiplicand(mult_multiplicand),
    .mult_multiplier(mult_multiplier),
    .mult_product(mult_product),
    .mult_resultRDY(mult_resultRDY),
    .mult_overflow(mult_overflow),
    .div_start(div_start),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_quotient(div_quotient),
    .div_resultRDY(div_resultRDY),
    .div_exception(div_exception),
    .stall(stall),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .result_tag(result_tag)
  );

  function automatic logic mul_ovf(logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p > PMAX) || (p < PMIN);
  endfunction

  // Multiplier stub: done flag stays high until the next load.
  always @(posedge clock) begin
    if (mult_start) begin
      mcnt <= MLAT;
      mult_resultRDY <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt <= 0;
      if (!mhang) begin
        mult_resultRDY <= 1;
        mult_product <= mult_multiplicand * mult_multiplier;
        mult_overflow <= mul_ovf(mult_multiplicand, mult_multiplier);
      end
    end
  end

  always @(posedge clock) begin
    if (div_start) begin
      dcnt <= DLAT;
      div_resultRDY <= 0;
    end else if (dcnt > 1) begin
      dcnt <= dcnt - 1;
    end else if (dcnt == 1) begin
      dcnt <= 0;
      div_resultRDY <= 1;
      div_quotient <= $signed(div_dividend) / $signed(div_divisor);
      div_exception <= 0;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(bit mul, logic [31:0] a,
                                 logic [31:0] b, logic [TW-1:0] t,
                                 bit hang);
    exp_t e;
    e.t = t;
    if (hang || (!mul && b == 0)) begin
      e.r = 0;
      e.x = 1;
    end else if (mul) begin
      e.r = a * b;
      e.x = mul_ovf(a, b);
    end else begin
      e.r = $signed(a) / $signed(b);
      e.x = 0;
    end
    return e;
  endfunction

  // Request edge to strobe cycle: launch, unit latency, capture, done.
  function automatic int model_lat(bit mul, logic [31:0] b, bit hang);
    if (!mul && b == 0) return 1;
    if (hang) return MAXC + 2;
    return (mul ? MLAT : DLAT) + 3;
  endfunction

  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_strobe: got %h, expected none",
                 data_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", data_result, e.r);
        chk("exception", data_exception, e.x);
        chk("tag", result_tag, e.t);
        chk("stall_in_done", stall, 0);
      end
    end
  end

  task automatic zero_chk(string p);
    chk({p, "_result"}, data_result, 0);
    chk({p, "_exc"}, data_exception, 0);
    chk({p, "_rdy"}, data_resultRDY, 0);
    chk({p, "_stall"}, stall, 0);
    chk({p, "_tag"}, result_tag, 0);
    chk({p, "_opa"}, mult_multiplicand, 0);
    chk({p, "_opb"}, div_divisor, 0);
    chk({p, "_starts"}, {mult_start, div_start}, 0);
  endtask

  task automatic run(input bit mul, input logic [31:0] a,
                     input logic [31:0] b, input logic [TW-1:0] t,
                     input bit hang, input int inj_at);
    int lat, nst, nms, nds, elat;
    exp_t e;
    e = model(mul, a, b, t, hang);
    elat = model_lat(mul, b, hang);
    @(negedge clock);
    mhang = hang;
    q.push_back(e);
    ctrl_MULT = mul;
    ctrl_DIV = !mul;
    data_operandA = a;
    data_operandB = b;
    dest_tag = t;
    @(negedge clock);
    ctrl_MULT = 0;
    ctrl_DIV = 0;
    lat = 1;
    nst = 0;
    nms = 0;
    nds = 0;
    while (!data_resultRDY && lat < 100) begin
      if (stall) nst++;
      if (mult_start) nms++;
      if (div_start) nds++;
      if (lat == inj_at) begin
        ctrl_MULT = 1;
        data_operandA = 3;
        data_operandB = 3;
        dest_tag = 9;
      end
      @(negedge clock);
      ctrl_MULT = 0;
      lat++;
    end
    chk("latency", lat, elat);
    chk("stall_cycles", nst, elat - 1);
    chk("mult_starts", nms, (mul && !hang) || (mul && hang));
    chk("div_starts", nds, !mul && b != 0);
    chk("opa_held", mult_multiplicand, a);
    chk("opb_held", div_divisor, b);
    @(negedge clock);
    chk("strobe_single", data_resultRDY, 0);
    chk("result_held", data_result, e.r);
  endtask

  initial begin
    int nstrobe;
    repeat (3) @(negedge clock);
    zero_chk("reset");
    reset = 0;

    run(1, 2, 7, 3, 0, 0);
    chk("pin_2x7", data_result, 14);
    chk("pin_2x7_tag", result_tag, 3);

    run(1, -5, 3, 4, 0, 0);
    chk("pin_neg", data_result, 32'hFFFFFFF1);
    chk("pin_neg_exc", data_exception, 0);

    run(1, 32'h7FFFFFFF, 2, 5, 0, 0);
    chk("pin_ovf_exc", data_exception, 1);

    run(0, 100, 0, 6, 0, 0);
    chk("pin_div0", {data_result[0], data_exception}, 2'b01);

    run(0, 100, 7, 7, 0, 0);
    chk("pin_div", data_result, 14);

    run(1, 2, 7, 8, 0, 5);
    chk("pin_inject", data_result, 14);
    nstrobe = 0;
    repeat (25) begin
      @(negedge clock);
      if (data_resultRDY) nstrobe++;
    end
    chk("inject_no_strobe", nstrobe, 0);

    run(1, 5, 6, 10, 1, 0);
    chk("pin_timeout", {data_result[0], data_exception}, 2'b01);

    @(negedge clock);
    mhang = 0;
    q.push_back(model(1, 2, 7, 11, 0));
    ctrl_MULT = 1;
    data_operandA = 2;
    data_operandB = 7;
    dest_tag = 11;
    @(negedge clock);
    ctrl_MULT = 0;
    repeat (5) @(negedge clock);
    chk("midwait_stall", stall, 1);
    reset = 1;
    @(negedge clock);
    zero_chk("midreset");
    reset = 0;
    q.delete();
    nstrobe = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY) nstrobe++;
    end
    chk("reset_no_strobe", nstrobe, 0);

    run(1, 2, 7, 12, 0, 0);
    chk("pin_after_reset", data_result, 14);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
